// File: rtl/access_requester.sv
// ----------------------------------------------------------------------------
// access_requester
//
// Initiator side of the request/confirm/user access handshake. On a host
// start it presents a latched code on 'user', raises 'request', issues two
// confirm pulses and then waits for the access controller to grant either
// the P or the Q path. A timed-out attempt is released and retried up to
// MAX_RETRY times. The outcome is reported with a one-cycle 'done' pulse and
// result flags that hold until the next accepted start.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   host pulse, accepted only when idle
//   code_in    in   code to present, latched on an accepted start
//   hold       in   host keeps a granted session open while high
//   abort      in   host cancels the attempt (no retry)
//   grant_p    in   controller P-path grant
//   grant_q    in   controller Q-path grant
//   request    out  request line to the controller
//   confirm    out  confirm line to the controller
//   user       out  code presented to the controller
//   busy       out  high whenever not idle
//   done       out  one-cycle completion pulse
//   granted_p  out  result: P grant obtained
//   granted_q  out  result: Q grant obtained
//   denied     out  result: no grant, aborted, or grant lost
//   attempts   out  attempts made in the last operation
// ----------------------------------------------------------------------------
module access_requester #(
    parameter int CW             = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT        = 16,
    parameter int RELEASE_CYCLES = 2,
    parameter int MAX_RETRY      = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] code_in,
    input  logic          hold,
    input  logic          abort,
    input  logic          grant_p,
    input  logic          grant_q,
    output logic          request,
    output logic          confirm,
    output logic [CW-1:0] user,
    output logic          busy,
    output logic          done,
    output logic          granted_p,
    output logic          granted_q,
    output logic          denied,
    output logic [3:0]    attempts
);

    // One phase counter serves SETUP, GAP, WAIT and RELEASE, so it is sized
    // for the longest of them.
    localparam int MAX_A   = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int MAX_B   = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int MAX_CNT = (MAX_B > RELEASE_CYCLES) ? MAX_B : RELEASE_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_CONF1,
        S_GAP,
        S_CONF2,
        S_WAIT,
        S_HOLD,
        S_RELEASE,
        S_DONE
    } state_t;

    // Why the current attempt is being released; decides retry vs. finish.
    typedef enum logic [1:0] {
        R_SUCCESS,
        R_FAIL,
        R_ABORT,
        R_LOST
    } reason_t;

    state_t           state, state_nxt;
    reason_t          reason, reason_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retries, retries_nxt;
    logic [CW-1:0]    user_nxt;
    logic             granted_p_nxt, granted_q_nxt, denied_nxt;
    logic [3:0]       attempts_nxt;
    logic             request_nxt, confirm_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            reason    <= R_SUCCESS;
            cnt       <= '0;
            retries   <= '0;
            user      <= '0;
            granted_p <= 1'b0;
            granted_q <= 1'b0;
            denied    <= 1'b0;
            attempts  <= '0;
            request   <= 1'b0;
            confirm   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            reason    <= reason_nxt;
            cnt       <= cnt_nxt;
            retries   <= retries_nxt;
            user      <= user_nxt;
            granted_p <= granted_p_nxt;
            granted_q <= granted_q_nxt;
            denied    <= denied_nxt;
            attempts  <= attempts_nxt;
            request   <= request_nxt;
            confirm   <= confirm_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        reason_nxt    = reason;
        cnt_nxt       = cnt;
        retries_nxt   = retries;
        user_nxt      = user;
        granted_p_nxt = granted_p;
        granted_q_nxt = granted_q;
        denied_nxt    = denied;
        attempts_nxt  = attempts;

        // abort outranks any grant or timeout seen in the same cycle
        if (abort && (state inside {S_SETUP, S_CONF1, S_GAP, S_CONF2, S_WAIT, S_HOLD})) begin
            state_nxt  = S_RELEASE;
            cnt_nxt    = '0;
            reason_nxt = R_ABORT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt     = S_SETUP;
                        cnt_nxt       = '0;
                        retries_nxt   = '0;
                        user_nxt      = code_in;
                        granted_p_nxt = 1'b0;
                        granted_q_nxt = 1'b0;
                        denied_nxt    = 1'b0;
                        attempts_nxt  = 4'd1;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state_nxt = S_CONF1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_CONF1: begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = S_CONF2;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_CONF2: begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end
                S_WAIT: begin
                    // A grant seen on the final timer cycle still counts;
                    // P wins when both paths grant together.
                    if (grant_p) begin
                        state_nxt     = S_HOLD;
                        granted_p_nxt = 1'b1;
                    end else if (grant_q) begin
                        state_nxt     = S_HOLD;
                        granted_q_nxt = 1'b1;
                    end else if (cnt == WAIT_LAST) begin
                        state_nxt  = S_RELEASE;
                        cnt_nxt    = '0;
                        reason_nxt = R_FAIL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        state_nxt  = S_RELEASE;
                        cnt_nxt    = '0;
                        reason_nxt = R_SUCCESS;
                    end else if (!grant_p && !grant_q) begin
                        state_nxt     = S_RELEASE;
                        cnt_nxt       = '0;
                        reason_nxt    = R_LOST;
                        granted_p_nxt = 1'b0;
                        granted_q_nxt = 1'b0;
                        denied_nxt    = 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == RELEASE_LAST) begin
                        cnt_nxt = '0;
                        if (reason == R_SUCCESS) begin
                            state_nxt = S_DONE;
                        end else if (reason == R_FAIL && retries < RETRY_LIMIT) begin
                            state_nxt    = S_SETUP;
                            retries_nxt  = retries + 4'd1;
                            attempts_nxt = (attempts == 4'hF) ? attempts : attempts + 4'd1;
                        end else begin
                            state_nxt  = S_DONE;
                            denied_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        // Line outputs are registered from the next state so they change on
        // the same edge as the state itself.
        request_nxt = state_nxt inside {S_SETUP, S_CONF1, S_GAP, S_CONF2, S_WAIT, S_HOLD};
        confirm_nxt = state_nxt inside {S_CONF1, S_CONF2};
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_access_requester.sv
// ----------------------------------------------------------------------------
// tb_access_requester
//
// Self-checking bench for access_requester. A table of scenarios with
// hand-derived outcomes is run first, followed by reset and randomized
// scenarios. Per-cycle expectations for request/confirm/busy/done come from
// the attempt timeline arithmetic (setup, two confirms, wait window,
// release) rather than from a state machine.
// ----------------------------------------------------------------------------
module tb_access_requester;

    localparam int CW        = 8;
    localparam int S         = 2;
    localparam int G         = 1;
    localparam int T         = 16;
    localparam int R         = 2;
    localparam int MAX_RETRY = 2;
    localparam int A         = S + G + 2;   // attempt start to first WAIT cycle
    localparam int P         = A + T + R;   // length of a timed-out attempt

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] code_in;
    logic          hold;
    logic          abort;
    logic          grant_p;
    logic          grant_q;
    logic          request;
    logic          confirm;
    logic [CW-1:0] user;
    logic          busy;
    logic          done;
    logic          granted_p;
    logic          granted_q;
    logic          denied;
    logic [3:0]    attempts;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;

    // kind: 0 granted, 1 every attempt times out, 2 aborted, 3 grant lost
    typedef struct {
        int         kind;
        int         fails;
        int         gsel;
        int         delay;
        int         hold_len;
        int         lost_at;
        int         abort_at;
        logic [7:0] code;
        logic       exp_p;
        logic       exp_q;
        logic       exp_denied;
        int         exp_attempts;
    } vec_t;

    vec_t vectors[10];

    access_requester #(
        .CW(CW), .SETUP_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT(T),
        .RELEASE_CYCLES(R), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .code_in(code_in),
        .hold(hold), .abort(abort), .grant_p(grant_p), .grant_q(grant_q),
        .request(request), .confirm(confirm), .user(user), .busy(busy),
        .done(done), .granted_p(granted_p), .granted_q(granted_q),
        .denied(denied), .attempts(attempts)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Outcome of a scenario from the result rules alone.
    function automatic vec_t model_outcome(input vec_t v);
        vec_t r;
        r = v;
        case (v.kind)
            0: begin
                r.exp_p = (v.gsel != 2);
                r.exp_q = (v.gsel == 2);
                r.exp_denied = 1'b0;
                r.exp_attempts = v.fails + 1;
            end
            1: begin
                r.exp_p = 1'b0; r.exp_q = 1'b0; r.exp_denied = 1'b1;
                r.exp_attempts = MAX_RETRY + 1;
            end
            2: begin
                r.exp_p = 1'b0; r.exp_q = 1'b0; r.exp_denied = 1'b1;
                r.exp_attempts = 1;
            end
            default: begin
                r.exp_p = 1'b0; r.exp_q = 1'b0; r.exp_denied = 1'b1;
                r.exp_attempts = v.fails + 1;
            end
        endcase
        return r;
    endfunction

    // Runs one operation from an idle DUT and checks it cycle by cycle.
    task automatic applyStimulus(input vec_t v);
        int   t, n_att, w_last, done_cycle, rel_start, g_end, hold_end, s, e;
        logic exp_req, exp_conf, grant_on;
        t = cyc;
        case (v.kind)
            1:       n_att = MAX_RETRY + 1;
            2:       n_att = 1;
            default: n_att = v.fails + 1;
        endcase
        w_last = t + 1 + (n_att - 1) * P + A;
        case (v.kind)
            0:       done_cycle = w_last + v.delay + 2 + v.hold_len + R;
            1:       done_cycle = t + 1 + n_att * P;
            2:       done_cycle = t + v.abort_at + 1 + R;
            default: done_cycle = w_last + v.delay + 2 + v.lost_at + R;
        endcase
        rel_start = done_cycle - R;
        g_end    = (v.kind == 3) ? w_last + v.delay + 1 + v.lost_at : done_cycle + 1;
        hold_end = (v.kind == 0) ? w_last + v.delay + 1 + v.hold_len : done_cycle + 1;

        for (int c = t; c <= done_cycle + 1; c++) begin
            if (c == t) begin
                checkOutput("idle_busy", busy, 0);
            end else begin
                exp_req  = 1'b0;
                exp_conf = 1'b0;
                for (int a = 0; a < n_att; a++) begin
                    s = t + 1 + a * P;
                    e = (a == n_att - 1) ? rel_start : s + A + T;
                    if (c >= s && c < e) exp_req = 1'b1;
                    if ((c == s + S || c == s + S + G + 1) && c < e) exp_conf = 1'b1;
                end
                checkOutput("request", request, exp_req);
                checkOutput("confirm", confirm, exp_conf);
                checkOutput("busy", busy, c <= done_cycle);
                checkOutput("done", done, c == done_cycle);
                checkOutput("user", user, v.code);
                if (c == t + 1) begin
                    checkOutput("start_granted_p", granted_p, 0);
                    checkOutput("start_granted_q", granted_q, 0);
                    checkOutput("start_denied", denied, 0);
                    checkOutput("start_attempts", attempts, 1);
                end
                if (v.kind == 0 && c > w_last + v.delay && c < done_cycle) begin
                    checkOutput("hold_granted_p", granted_p, v.exp_p);
                end
                if (c >= done_cycle) begin
                    checkOutput("granted_p", granted_p, v.exp_p);
                    checkOutput("granted_q", granted_q, v.exp_q);
                    checkOutput("denied", denied, v.exp_denied);
                    checkOutput("attempts", attempts, v.exp_attempts);
                end
            end

            if (c > done_cycle) begin
                start = 1'b0; abort = 1'b0; grant_p = 1'b0; grant_q = 1'b0; hold = 1'b0;
            end else begin
                // extra starts and code changes while busy must be ignored
                start   = (c == t) || ($urandom_range(0, 5) == 0);
                code_in = (c == t) ? v.code : CW'($urandom);
                abort   = (v.kind == 2 && c == t + v.abort_at);
                grant_on = (v.kind == 0 || v.kind == 3) && c >= w_last + v.delay && c < g_end;
                grant_p = (grant_on && v.gsel != 2) || (abort && v.abort_at >= A);
                grant_q = grant_on && v.gsel != 1;
                if ((v.kind == 0 || v.kind == 3) && c >= w_last + v.delay + 1)
                    hold = (c < hold_end);
                else
                    hold = 1'($urandom_range(0, 1));
            end
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vec_t v;
        int t;

        //               kind fails gsel delay hold lost abort code   p     q     den   att
        vectors[0] = '{0, 0, 1, 1,  5, 0, 0,  8'h05, 1'b1, 1'b0, 1'b0, 1};
        vectors[1] = '{1, 0, 1, 0,  0, 0, 0,  8'hA5, 1'b0, 1'b0, 1'b1, 3};
        vectors[2] = '{0, 1, 2, 4,  3, 0, 0,  8'h5A, 1'b0, 1'b1, 1'b0, 2};
        vectors[3] = '{2, 0, 1, 0,  0, 0, 4,  8'h11, 1'b0, 1'b0, 1'b1, 1};
        vectors[4] = '{3, 0, 1, 0,  0, 3, 0,  8'h22, 1'b0, 1'b0, 1'b1, 1};
        vectors[5] = '{0, 0, 3, 0,  2, 0, 0,  8'h33, 1'b1, 1'b0, 1'b0, 1};
        vectors[6] = '{0, 2, 1, 15, 0, 0, 0,  8'h44, 1'b1, 1'b0, 1'b0, 3};
        vectors[7] = '{2, 0, 1, 0,  0, 0, 21, 8'h55, 1'b0, 1'b0, 1'b1, 1};
        vectors[8] = '{2, 0, 1, 0,  0, 0, 1,  8'h66, 1'b0, 1'b0, 1'b1, 1};
        vectors[9] = '{0, 0, 2, 0,  0, 0, 0,  8'h77, 1'b0, 1'b1, 1'b0, 1};

        reset_n = 1'b0;
        start = 1'b0; code_in = '0; hold = 1'b0; abort = 1'b0;
        grant_p = 1'b0; grant_q = 1'b0;
        step();
        step();
        checkOutput("rst_request", request, 0);
        checkOutput("rst_confirm", confirm, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_granted_p", granted_p, 0);
        checkOutput("rst_granted_q", granted_q, 0);
        checkOutput("rst_denied", denied, 0);
        checkOutput("rst_user", user, 0);
        checkOutput("rst_attempts", attempts, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i]);
        end

        // Reset asserted mid-WAIT clears everything without a release phase.
        t = cyc;
        start = 1'b1; code_in = 8'h3C; hold = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        checkOutput("wait_request", request, 1);
        checkOutput("wait_cycle", cyc - t, 8);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_request", request, 0);
        checkOutput("async_confirm", confirm, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_granted_p", granted_p, 0);
        checkOutput("async_denied", denied, 0);
        checkOutput("async_user", user, 0);
        checkOutput("async_attempts", attempts, 0);
        #1 reset_n = 1'b1;
        hold = 1'b0;
        step();
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_request", request, 0);

        for (int i = 0; i < 40; i++) begin
            v.kind     = $urandom_range(0, 3);
            v.fails    = $urandom_range(0, MAX_RETRY);
            v.gsel     = $urandom_range(1, 3);
            v.delay    = $urandom_range(0, T - 1);
            v.hold_len = $urandom_range(0, 6);
            v.lost_at  = $urandom_range(0, 6);
            v.abort_at = $urandom_range(1, A + T);
            v.code     = 8'($urandom);
            v = model_outcome(v);
            applyStimulus(v);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
